// File: rtl/ecc_err_cnt_rdout.sv
// Per-channel saturating sbiterr/dbiterr counters with snapshot and framed readout into a FIFO.
// Optional periodic auto-snapshot timer is enabled by defining ECC_ERR_AUTO_SNAP_EN.
module ecc_err_cnt_rdout #(
  parameter int N           = 32,
  parameter int CH          = 48,
  parameter int CW          = 16,
  parameter int SNAP_PERIOD = 100000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [CH-1:0] sbiterr_i,
  input  logic [CH-1:0] dbiterr_i,
  input  logic          snap_i,
  input  logic          fifo_full_i,
  input  logic          fifo_almst_full_i,
  output logic          fifo_wr_o,
  output logic [N-1:0]  fifo_data_o,
  output logic          busy_o,
  output logic          snap_miss_o,
  output logic          ovf_o
);

  localparam int IW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_TRL} state_t;

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_seq;
  logic [CW-1:0] r_sb_live [CH];
  logic [CW-1:0] r_db_live [CH];
  logic [CW-1:0] r_sb_shd  [CH];
  logic [CW-1:0] r_db_shd  [CH];

  logic w_auto_snap;
  logic w_snap_req;
  logic w_snap_acc;
  logic w_sat;

`ifdef ECC_ERR_AUTO_SNAP_EN
  localparam int TW = (SNAP_PERIOD > 1) ? $clog2(SNAP_PERIOD) : 1;
  logic [TW-1:0] r_tmr;

  always_ff @(posedge clk_i) begin
    if (rst_i)                               r_tmr <= '0;
    else if (r_tmr == TW'(SNAP_PERIOD - 1))  r_tmr <= '0;
    else                                     r_tmr <= r_tmr + TW'(1);
  end

  assign w_auto_snap = (r_tmr == TW'(SNAP_PERIOD - 1));
`else
  // Timer absent: the period parameter only feeds a constant-false request.
  assign w_auto_snap = (SNAP_PERIOD < 0);
`endif

  assign w_snap_req = snap_i | w_auto_snap;
  assign w_snap_acc = w_snap_req && (r_state == S_IDLE);

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    w_sat = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (r_sb_shd[i] == CNT_MAX || r_db_shd[i] == CNT_MAX) w_sat = 1'b1;
    end
  end

  // NOTE: counter arrays are reset explicitly because they must read 0 right after reset;
  // sequential state always uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CH; i++) begin
        r_sb_live[i] <= '0;
        r_db_live[i] <= '0;
        r_sb_shd[i]  <= '0;
        r_db_shd[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_snap_acc) begin
          // An event coincident with the snapshot belongs to the new period.
          r_sb_shd[i]  <= r_sb_live[i];
          r_db_shd[i]  <= r_db_live[i];
          r_sb_live[i] <= CW'(sbiterr_i[i]);
          r_db_live[i] <= CW'(dbiterr_i[i]);
        end else begin
          if (sbiterr_i[i] && r_sb_live[i] != CNT_MAX) r_sb_live[i] <= r_sb_live[i] + CW'(1);
          if (dbiterr_i[i] && r_db_live[i] != CNT_MAX) r_db_live[i] <= r_db_live[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_seq       <= '0;
      fifo_wr_o   <= 1'b0;
      fifo_data_o <= '0;
      busy_o      <= 1'b0;
      snap_miss_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      fifo_wr_o <= 1'b0;
      if (fifo_wr_o && fifo_full_i)          ovf_o       <= 1'b1;
      if (w_snap_req && r_state != S_IDLE)   snap_miss_o <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_snap_req) begin
            r_state <= S_HDR;
            busy_o  <= 1'b1;
          end
        end
        S_HDR: begin
          if (!fifo_almst_full_i) begin
            fifo_wr_o   <= 1'b1;
            fifo_data_o <= N'({16'hE0C0, r_seq});
            r_idx       <= '0;
            r_state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (!fifo_almst_full_i) begin
            fifo_wr_o   <= 1'b1;
            fifo_data_o <= N'({r_sb_shd[r_idx], r_db_shd[r_idx]});
            if (r_idx == IW'(CH - 1)) r_state <= S_TRL;
            else                      r_idx   <= r_idx + IW'(1);
          end
        end
        S_TRL: begin
          if (!fifo_almst_full_i) begin
            fifo_wr_o   <= 1'b1;
            fifo_data_o <= N'({16'hE0CF, 6'd0, snap_miss_o, w_sat, 8'(CH)});
            r_seq       <= r_seq + 16'd1;
            busy_o      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecc_err_cnt_rdout.sv
// Directed bench for ecc_err_cnt_rdout: vector table of single-record scenarios plus
// hand-written sequences for saturation, snapshot miss, back-pressure, overflow and reset abort.
module tb_ecc_err_cnt_rdout;

  localparam int N   = 32;
  localparam int CH  = 48;
  localparam int CW  = 16;
  localparam int REC = CH + 2;
`ifdef ECC_ERR_AUTO_SNAP_EN
  localparam int SP  = 200;
`else
  localparam int SP  = 100000;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [CH-1:0] sbiterr_i = '0;
  logic [CH-1:0] dbiterr_i = '0;
  logic          snap_i = 1'b0;
  logic          fifo_full_i = 1'b0;
  logic          fifo_almst_full_i = 1'b0;
  logic          fifo_wr_o;
  logic [N-1:0]  fifo_data_o;
  logic          busy_o;
  logic          snap_miss_o;
  logic          ovf_o;

  always #5 clk_i = ~clk_i;

  ecc_err_cnt_rdout #(.N(N), .CH(CH), .CW(CW), .SNAP_PERIOD(SP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .sbiterr_i(sbiterr_i), .dbiterr_i(dbiterr_i),
    .snap_i(snap_i), .fifo_full_i(fifo_full_i), .fifo_almst_full_i(fifo_almst_full_i),
    .fifo_wr_o(fifo_wr_o), .fifo_data_o(fifo_data_o), .busy_o(busy_o),
    .snap_miss_o(snap_miss_o), .ovf_o(ovf_o)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [31:0] got_q [$];
  int          got_t [$];
  logic [31:0] exp_rec [REC];

  always @(posedge clk_i) cyc++;
  always @(negedge clk_i) if (fifo_wr_o) begin
    got_q.push_back(fifo_data_o);
    got_t.push_back(cyc);
  end

  typedef struct {
    int          sb_ch;
    int          sb_n;
    int          db_ch;
    int          db_n;
    logic [31:0] exp_hdr;
    int          idx_a;
    logic [31:0] data_a;
    int          idx_b;
    logic [31:0] data_b;
    logic [31:0] exp_trl;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic wait_words(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk_i);
      k++;
    end
    check($sformatf("wait %0d words", n), 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic snap_pulse(output int t);
    snap_i = 1'b1;
    t = cyc;
    tick(1);
    snap_i = 1'b0;
  endtask

  task automatic set_base(input logic [15:0] seq, input logic [31:0] trl);
    exp_rec[0] = {16'hE0C0, seq};
    for (int i = 1; i < REC - 1; i++) exp_rec[i] = 32'h0;
    exp_rec[REC-1] = trl;
  endtask

  // Compares the oldest REC captured words against exp_rec and removes them.
  task automatic check_record(input string tag);
    for (int i = 0; i < REC; i++) begin
      if (got_q.size() > 0) begin
        check($sformatf("%s w%0d", tag, i), got_q.pop_front(), exp_rec[i]);
        void'(got_t.pop_front());
      end else begin
        check($sformatf("%s w%0d missing", tag, i), 32'hxxxxxxxx, exp_rec[i]);
      end
    end
  endtask

  task automatic run_vec(input int v);
    int n = (vecs[v].sb_n > vecs[v].db_n) ? vecs[v].sb_n : vecs[v].db_n;
    int t;
    for (int c = 0; c < n; c++) begin
      sbiterr_i = '0;
      dbiterr_i = '0;
      if (c < vecs[v].sb_n) sbiterr_i[vecs[v].sb_ch] = 1'b1;
      if (c < vecs[v].db_n) dbiterr_i[vecs[v].db_ch] = 1'b1;
      tick(1);
    end
    sbiterr_i = '0;
    dbiterr_i = '0;
    tick(1);
    snap_pulse(t);
    wait_words(REC, 200);
    tick(2);
    check($sformatf("vec%0d hdr latency", v), 32'(got_t[0] - t), 32'd2);
    check($sformatf("vec%0d count", v), 32'(got_q.size()), 32'(REC));
    exp_rec = '{default: 32'h0};
    set_base(vecs[v].exp_hdr[15:0], vecs[v].exp_trl);
    check($sformatf("vec%0d hdr", v), got_q.size() > 0 ? got_q[0] : 32'hx, vecs[v].exp_hdr);
    exp_rec[1 + vecs[v].idx_a] = vecs[v].data_a;
    if (vecs[v].idx_b >= 0) exp_rec[1 + vecs[v].idx_b] = vecs[v].data_b;
    check_record($sformatf("vec%0d", v));
  endtask

  initial begin
    int t;
    int n0;
    int n1;

    vecs[0] = '{sb_ch:0,  sb_n:1, db_ch:0,  db_n:0, exp_hdr:32'hE0C00000,
                idx_a:0,  data_a:32'h00010000, idx_b:-1, data_b:32'h0, exp_trl:32'hE0CF0030};
    vecs[1] = '{sb_ch:5,  sb_n:3, db_ch:5,  db_n:2, exp_hdr:32'hE0C00001,
                idx_a:5,  data_a:32'h00030002, idx_b:-1, data_b:32'h0, exp_trl:32'hE0CF0030};
    vecs[2] = '{sb_ch:20, sb_n:7, db_ch:47, db_n:1, exp_hdr:32'hE0C00002,
                idx_a:20, data_a:32'h00070000, idx_b:47, data_b:32'h00000001, exp_trl:32'hE0CF0030};
    vecs[3] = '{sb_ch:47, sb_n:0, db_ch:1,  db_n:4, exp_hdr:32'hE0C00003,
                idx_a:1,  data_a:32'h00000004, idx_b:-1, data_b:32'h0, exp_trl:32'hE0CF0030};

    tick(3);
    rst_i = 1'b0;

`ifdef ECC_ERR_AUTO_SNAP_EN
    wait_words(3 * REC, 1000);
    tick(2);
    if (got_q.size() >= 2 * REC + 1) begin
      check("auto hdr0", got_q[0], 32'hE0C00000);
      check("auto hdr1", got_q[REC], 32'hE0C00001);
      check("auto hdr2", got_q[2*REC], 32'hE0C00002);
      check("auto gap01", 32'(got_t[REC] - got_t[0]), 32'd200);
      check("auto gap12", 32'(got_t[2*REC] - got_t[REC]), 32'd200);
    end
    check("auto miss", 32'(snap_miss_o), 32'd0);
`else
    // Idle after reset: no writes, flags clear.
    tick(100);
    check("idle writes", 32'(got_q.size()), 32'd0);
    check("idle busy", 32'(busy_o), 32'd0);
    check("idle miss", 32'(snap_miss_o), 32'd0);
    check("idle ovf", 32'(ovf_o), 32'd0);
    check("idle data", fifo_data_o, 32'h0);

    for (int v = 0; v < 4; v++) run_vec(v);

    // Event coincident with snapshot is counted in the new period.
    sbiterr_i[2] = 1'b1;
    tick(1);
    sbiterr_i = '0;
    sbiterr_i[1] = 1'b1;
    snap_i = 1'b1;
    tick(1);
    sbiterr_i = '0;
    snap_i = 1'b0;
    wait_words(REC, 200);
    tick(2);
    set_base(16'd4, 32'hE0CF0030);
    exp_rec[1 + 2] = 32'h00010000;
    check_record("coinc seq4");
    snap_pulse(t);
    wait_words(REC, 200);
    tick(2);
    set_base(16'd5, 32'hE0CF0030);
    exp_rec[1 + 1] = 32'h00010000;
    check_record("coinc seq5");

    // Saturation of dbiterr on the last channel.
    dbiterr_i[47] = 1'b1;
    tick(70000);
    dbiterr_i = '0;
    snap_pulse(t);
    wait_words(REC, 200);
    tick(2);
    set_base(16'd6, 32'hE0CF0130);
    exp_rec[1 + 47] = 32'h0000FFFF;
    check_record("sat seq6");

    // Snapshot held high: dropped while busy, re-accepted on the edge after TRL.
    snap_i = 1'b1;
    wait_words(REC, 200);
    tick(1);
    snap_i = 1'b0;
    wait_words(2 * REC, 200);
    tick(2);
    check("miss sticky", 32'(snap_miss_o), 32'd1);
    check("miss count", 32'(got_q.size()), 32'(2 * REC));
    if (got_t.size() > REC) check("b2b hdr gap", 32'(got_t[REC] - got_t[REC-1]), 32'd2);
    set_base(16'd7, 32'hE0CF0230);
    check_record("miss seq7");
    set_base(16'd8, 32'hE0CF0230);
    check_record("miss seq8");

    // Back-pressure mid-DATA for 10 cycles.
    sbiterr_i[3] = 1'b1;
    tick(2);
    sbiterr_i = '0;
    snap_pulse(t);
    wait_words(10, 200);
    fifo_almst_full_i = 1'b1;
    tick(1);
    n0 = got_q.size();
    tick(9);
    n1 = got_q.size();
    check("stall busy", 32'(busy_o), 32'd1);
    fifo_almst_full_i = 1'b0;
    check("stall writes", 32'(n1), 32'(n0));
    wait_words(REC, 200);
    tick(2);
    check("stall count", 32'(got_q.size()), 32'(REC));
    set_base(16'd9, 32'hE0CF0230);
    exp_rec[1 + 3] = 32'h00020000;
    check_record("stall seq9");

    // Full while idle is harmless; full on a write sets ovf.
    fifo_full_i = 1'b1;
    tick(3);
    fifo_full_i = 1'b0;
    tick(1);
    check("ovf idle", 32'(ovf_o), 32'd0);
    snap_pulse(t);
    tick(3);
    fifo_full_i = 1'b1;
    tick(1);
    fifo_full_i = 1'b0;
    wait_words(REC, 200);
    tick(2);
    check("ovf set", 32'(ovf_o), 32'd1);
    check("ovf count", 32'(got_q.size()), 32'(REC));
    set_base(16'd10, 32'hE0CF0230);
    check_record("ovf seq10");

    // Reset mid-record aborts it with no trailer.
    snap_pulse(t);
    wait_words(10, 200);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst wr", 32'(fifo_wr_o), 32'd0);
    check("rst ovf", 32'(ovf_o), 32'd0);
    check("rst miss", 32'(snap_miss_o), 32'd0);
    n0 = got_q.size();
    tick(60);
    check("rst no trailer", 32'(got_q.size()), 32'(n0));
    got_q.delete();
    got_t.delete();
    snap_pulse(t);
    wait_words(REC, 200);
    tick(2);
    check("rst count", 32'(got_q.size()), 32'(REC));
    set_base(16'd0, 32'hE0CF0030);
    check_record("rst seq0");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
